// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IBUSY = 2'd1,
    DBUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  localparam int unsigned TIMEOUT_DEFAULT = 255;
  localparam int unsigned CNT_W           = 16;

endpackage

// File: rtl/arb_timer.sv
// Wait counter for an outstanding memory access; expired marks the cycle in
// which the TIMEOUT-th ack-less busy cycle completes.
module arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating increment: the counter never wraps inside one transaction.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one memory port with
// alternating priority on ties, a per-access timeout and a sticky error flag.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          AW      = 32,
  parameter int          DW      = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic [DW-1:0] i_rdata,
  output logic          i_ready,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          m_req,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  input  logic          m_ack,
  output logic          stall_i,
  output logic          stall_d,
  output logic          err
);

  arb_state_t    state_q, state_d;
  grant_t        last_grant_q, last_grant_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          err_q, err_d;

  logic busy;
  logic ack;
  logic timeout;
  logic done;

  assign busy = (state_q != IDLE);
  assign ack  = busy & m_ack;

  // Counter is held clear while idle, so it is zero on the first busy cycle.
  arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (~busy),
    .enable  (busy & ~m_ack),
    .expired (timeout)
  );

  assign done = ack | timeout;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    m_we_d       = m_we_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    err_d        = err_q;

    case (state_q)
      IDLE: begin
        // On a tie the port that was not granted last wins.
        if (d_req && (!i_req || (last_grant_q == GRANT_I))) begin
          state_d      = DBUSY;
          last_grant_d = GRANT_D;
          m_we_d       = d_we;
          m_addr_d     = d_addr;
          m_wdata_d    = d_wdata;
        end else if (i_req) begin
          state_d      = IBUSY;
          last_grant_d = GRANT_I;
          m_we_d       = 1'b0;
          m_addr_d     = i_addr;
          m_wdata_d    = '0;
        end
      end
      IBUSY, DBUSY: begin
        if (done) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (timeout) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      m_we_q       <= 1'b0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      m_we_q       <= m_we_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      err_q        <= err_d;
    end
  end

  assign m_req   = busy;
  assign m_we    = m_we_q;
  assign m_addr  = m_addr_q;
  assign m_wdata = m_wdata_q;
  assign err     = err_q;

  // Read data is only exposed on a real ack; a timeout returns zero.
  assign i_ready = (state_q == IBUSY) & done;
  assign d_ready = (state_q == DBUSY) & done;
  assign i_rdata = ((state_q == IBUSY) && ack) ? m_rdata : '0;
  assign d_rdata = ((state_q == DBUSY) && ack) ? m_rdata : '0;

  assign stall_i = i_req & ~i_ready;
  assign stall_d = d_req & ~d_ready;

endmodule
